// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and helpers for the I2C bus arbiter: FSM state encoding,
// command field widths and the round-robin pointer wrap.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ABORT   = 2'd3
    } arb_state_t;

    localparam int DW_DEFAULT = 8;
    localparam int CMD_W      = 3;   // start, stop, write

    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and master-side command/status bundle of the I2C bus arbiter.
// The master modport is the arbiter's view; slave is the requesters/master view.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 8
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    granted;
    logic [NUM_REQ-1:0]    start_i;
    logic [NUM_REQ-1:0]    stop_i;
    logic [NUM_REQ-1:0]    write_i;
    logic [NUM_REQ*DW-1:0] data_in_i;
    logic [NUM_REQ-1:0]    done_o;
    logic [NUM_REQ-1:0]    busy_o;
    logic [NUM_REQ-1:0]    ack_err_o;

    logic                  m_start;
    logic                  m_stop;
    logic                  m_write;
    logic [DW-1:0]         m_data;
    logic                  m_done;
    logic                  m_busy;
    logic                  m_ack_err;

    modport master (
        input  req, start_i, stop_i, write_i, data_in_i,
        input  m_done, m_busy, m_ack_err,
        output granted, done_o, busy_o, ack_err_o,
        output m_start, m_stop, m_write, m_data
    );

    modport slave (
        output req, start_i, stop_i, write_i, data_in_i,
        output m_done, m_busy, m_ack_err,
        input  granted, done_o, busy_o, ack_err_o,
        input  m_start, m_stop, m_write, m_data
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after rr_ptr.
module i2c_bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    function automatic int slot(input logic [IW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // Scan from farthest to nearest so the slot closest to rr_ptr wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[slot(rr_ptr, k)]) begin
                idx   = IW'(slot(rr_ptr, k));
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between NUM_REQ
// requesters, with a watchdog that aborts an owner stalling the bus.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DW             = DW_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    i2c_bus_arbiter_if.master  bus,
    output logic [IW-1:0]      owner,
    output logic               timeout_err
);

    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam bit                WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0]   WD_MAX  = '1;

    arb_state_t          state, state_nx;
    logic [NUM_REQ-1:0]  granted, granted_nx;
    logic [IW-1:0]       owner_nx;
    logic [IW-1:0]       rr_ptr, rr_ptr_nx;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_nx;
    logic                timeout_nx;
    logic                abort_first, abort_first_nx;
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;
    logic [IW-1:0]       owner_inc;

    i2c_bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign owner_inc   = IW'(wrap_inc(int'(owner), NUM_REQ));
    assign bus.granted = granted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            granted     <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            abort_first <= 1'b0;
        end else begin
            state       <= state_nx;
            granted     <= granted_nx;
            owner       <= owner_nx;
            rr_ptr      <= rr_ptr_nx;
            wd_cnt      <= wd_cnt_nx;
            timeout_err <= timeout_nx;
            abort_first <= abort_first_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        granted_nx     = granted;
        owner_nx       = owner;
        rr_ptr_nx      = rr_ptr;
        wd_cnt_nx      = wd_cnt;
        timeout_nx     = 1'b0;
        abort_first_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_nx   = pick_idx;
                    granted_nx = NUM_REQ'(1) << pick_idx;
                    wd_cnt_nx  = '0;
                    state_nx   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release takes priority over a watchdog expiry in the same cycle.
                if (!bus.req[owner]) begin
                    granted_nx = '0;
                    rr_ptr_nx  = owner_inc;
                    state_nx   = ST_RELEASE;
                end else if (WD_EN && !bus.m_done && wd_cnt == WD_LAST) begin
                    granted_nx     = '0;
                    rr_ptr_nx      = owner_inc;
                    timeout_nx     = 1'b1;
                    abort_first_nx = 1'b1;
                    state_nx       = ST_ABORT;
                end else if (bus.m_done) begin
                    wd_cnt_nx = '0;
                end else if (WD_EN && wd_cnt != WD_MAX) begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
            end
            ST_RELEASE, ST_ABORT: begin
                if (!bus.m_busy) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.m_start   = 1'b0;
        bus.m_stop    = 1'b0;
        bus.m_write   = 1'b0;
        bus.m_data    = '0;
        bus.done_o    = '0;
        bus.ack_err_o = '0;
        bus.busy_o    = '0;
        unique case (state)
            ST_GRANT: begin
                bus.m_start          = bus.start_i[owner];
                bus.m_stop           = bus.stop_i[owner];
                bus.m_write          = bus.write_i[owner];
                bus.m_data           = bus.data_in_i[int'(owner)*DW +: DW];
                bus.done_o[owner]    = bus.m_done;
                bus.ack_err_o[owner] = bus.m_ack_err;
                bus.busy_o           = '1;
                bus.busy_o[owner]    = bus.m_busy;
            end
            ST_RELEASE: begin
                bus.busy_o = {NUM_REQ{bus.m_busy}};
            end
            ST_ABORT: begin
                // Close out the stalled transfer once, only if one is in flight.
                bus.m_stop = abort_first & bus.m_busy;
                bus.busy_o = {NUM_REQ{bus.m_busy}};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_master command port between NUM_REQ requesters (OLED_fsm on port 0, sensor/aux controllers on higher ports), using the existing req/granted handshake.
- Round-robin grant at transaction boundaries.
- Muxes start/stop/write/data_in to the master; routes done/busy/ack_err back to the current owner only.
- Watchdog aborts an owner that stalls the bus, then frees it for other requesters.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DW, 8, data_in width
- TIMEOUT_CYCLES, 2_000_000, clk cycles in GRANT without m_done before abort; 0 disables watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester bus request (level)
- granted  out  NUM_REQ  one-hot grant, registered
- start_i  in  NUM_REQ  per-requester start pulse
- stop_i  in  NUM_REQ  per-requester stop pulse
- write_i  in  NUM_REQ  per-requester write pulse
- data_in_i  in  NUM_REQ*DW  per-requester byte; slice i = [i*DW +: DW]
- done_o  out  NUM_REQ  m_done routed to owner
- busy_o  out  NUM_REQ  owner: m_busy; non-owner: 1 while bus held
- ack_err_o  out  NUM_REQ  m_ack_err routed to owner
- m_start, m_stop, m_write  out  1 each  to i2c_master
- m_data  out  DW  to i2c_master data_in
- m_done, m_busy, m_ack_err  in  1 each  from i2c_master
- owner  out  clog2(NUM_REQ)  current/last owner index
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; granted=0; owner=0; rr_ptr=0; wd_cnt=0; timeout_err=0.
  - m_* outputs, done_o, ack_err_o all 0; busy_o=0.
- States: IDLE, GRANT, RELEASE, ABORT.
- IDLE:
  - Any req bit set → choose first set bit scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - owner<=idx; granted<=onehot(idx); state<=GRANT.
  - Latency req→granted is 1 cycle.
- GRANT:
  - m_start/m_stop/m_write/m_data = owner's inputs, combinational pass-through.
  - Non-owner start/stop/write are ignored (dropped, not queued).
  - done_o[owner]=m_done; ack_err_o[owner]=m_ack_err; other bits 0.
  - busy_o[owner]=m_busy; busy_o[other]=1.
- Release: req[owner]=0 in GRANT → granted<=0, state<=RELEASE, rr_ptr<=owner+1 (wrap). Command mux is forced to 0 from the next cycle.
- RELEASE: stay until m_busy=0, then IDLE. Guarantees ≥1 idle cycle between owners and that no owner change happens mid-transaction.
- Watchdog, active only when TIMEOUT_CYCLES>0:
  - wd_cnt clears on entry to GRANT and on every m_done; otherwise increments in GRANT, saturating.
  - wd_cnt==TIMEOUT_CYCLES-1 and no m_done → granted<=0, state<=ABORT, timeout_err pulses 1 cycle, rr_ptr<=owner+1.
- ABORT:
  - First cycle drives m_stop=1 (only if m_busy=1), then waits m_busy=0 → IDLE.
  - Aborted requester re-arbitrates normally; it gets lowest priority next round.
- Simultaneous events:
  - m_done and req[owner] fall in the same cycle → done_o[owner] still pulses that cycle, then RELEASE.
  - Watchdog expiry and req[owner] fall in the same cycle → release wins; no timeout_err.
  - New req during RELEASE/ABORT → held until IDLE.
  - req of a non-owner never preempts.
- Reset mid-transaction: all outputs return to reset values immediately. The master is reset by the same reset.
- owner holds its last value in IDLE.

Decomposition:
- Shared package (i2c_pkg):
  - state encoding (IDLE=0, GRANT=1, RELEASE=2, ABORT=3)
  - DW default, I2C command field widths
- One natural sub-module: rr_pick — combinational round-robin priority encoder (req, rr_ptr → idx, valid).
- Watchdog counter stays inline.

Test Plan:
- Single requester: req[0]=1 → granted=01 next cycle. OLED write sequence passes through with m_data==data_in_i[7:0] each write. req[0]=0 with m_busy=0 → granted=00, owner=0, back to IDLE 1 cycle later.
- Contention: req=11 from reset → granted=01 first. Drop req[0] → granted=10 after RELEASE. Raise req[0] again while owner=1; drop req[1] → granted=01 (round-robin order 0,1,0).
- Isolation: owner=0; requester 1 pulses start_i[1], write_i[1] with data 0xAA → m_start/m_write stay 0, m_data≠0xAA. busy_o[1]=1 and done_o[1]=0 throughout.
- Release while busy: req[0] drops while m_busy=1 → granted=0 at once. Pending req[1] is granted only after m_busy falls plus 1 cycle.
- Watchdog with TIMEOUT_CYCLES=16: owner 0 holds req, no m_done, m_busy=1 → timeout_err pulses at cycle 16, m_stop pulses once. After m_busy=0 with req=11 → granted=10.
- Async reset with reset=0 mid-GRANT (m_busy=1) → granted, m_* and timeout_err all 0 without a clock edge. After release, arbitration restarts at requester 0.
